// File: rtl/arith_pkg.sv
// Shared helpers for the pipelined arithmetic blocks: slice sizing and
// parameter legality shared by every user of the carry-chain slicing.
package arith_pkg;

  function automatic int chunk_width(input int width, input int stages);
    return (stages > 0) ? width / stages : width;
  endfunction

  function automatic bit params_legal(input int width, input int stages);
    return (width >= 2) && (stages >= 1) && (stages <= width) &&
           ((width % stages) == 0);
  endfunction

endpackage

// File: rtl/adder_slice.sv
// Combinational N-bit ripple-carry adder built from full-adder cells; one
// instance forms each registered slice of the pipelined carry chain.
module adder_slice #(
  parameter int N = 4
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  output logic [N-1:0] sum,
  output logic         cout
);

  logic [N:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < N; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1]   = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[N];

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: the carry chain is cut into STAGES slices with
// skewed operands and deskewed partial sums, under a valid/ready handshake.
module pipelined_adder
  import arith_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int CHUNK = chunk_width(WIDTH, STAGES);
  localparam int LAST  = STAGES - 1;

  if (!params_legal(WIDTH, STAGES)) begin : g_param_check
    $error("pipelined_adder: illegal WIDTH/STAGES combination");
  end

  logic              adv;
  logic [STAGES-1:0] vld;
  logic [WIDTH-1:0]  b_eff;

  assign out_valid = vld[LAST];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;
  assign b_eff     = sub ? ~b : b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (adv) begin
      vld[0] <= in_valid;
      for (int i = 1; i < STAGES; i++) vld[i] <= vld[i-1];
    end
  end

  // Stage k works on the operand bits not yet summed (a_rem/b_rem) and
  // accumulates the finished low sum bits in acc for the next stage.
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * CHUNK;
    localparam int REM = WIDTH - LO;

    logic [REM-1:0]      a_rem;
    logic [REM-1:0]      b_rem;
    logic                cin_rem;
    logic [CHUNK-1:0]    slice_sum;
    logic                slice_cout;
    logic [LO+CHUNK-1:0] acc;

    adder_slice #(.N(CHUNK)) u_slice (
      .a   (a_rem[CHUNK-1:0]),
      .b   (b_rem[CHUNK-1:0]),
      .cin (cin_rem),
      .sum (slice_sum),
      .cout(slice_cout)
    );

    if (k == 0) begin : g_in
      assign a_rem   = a;
      assign b_rem   = b_eff;
      assign cin_rem = carry_in;
      assign acc     = slice_sum;
    end else begin : g_reg
      logic [LO-1:0] low_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_rem   <= '0;
          b_rem   <= '0;
          cin_rem <= 1'b0;
          low_q   <= '0;
        end else if (adv) begin
          a_rem   <= g_stage[k-1].a_rem[REM+CHUNK-1:CHUNK];
          b_rem   <= g_stage[k-1].b_rem[REM+CHUNK-1:CHUNK];
          cin_rem <= g_stage[k-1].slice_cout;
          low_q   <= g_stage[k-1].acc;
        end
      end

      assign acc = {slice_sum, low_q};
    end
  end

  logic a_msb, b_msb, s_msb;

  assign a_msb = g_stage[LAST].a_rem[CHUNK-1];
  assign b_msb = g_stage[LAST].b_rem[CHUNK-1];
  assign s_msb = g_stage[LAST].slice_sum[CHUNK-1];

  // The output register is the final pipeline stage; overflow uses the
  // operand MSBs that were skewed all the way to the top slice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum       <= '0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else if (adv) begin
      sum       <= g_stage[LAST].acc;
      carry_out <= g_stage[LAST].slice_cout;
      overflow  <= (a_msb == b_msb) && (s_msb != a_msb);
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Randomised and directed bench for pipelined_adder, checked against a
// queue-based arithmetic reference model with handshake and latency checks.
module tb_pipelined_adder;

  localparam int WIDTH  = 16;
  localparam int STAGES = 4;
  localparam int SMAX   = 2 ** (WIDTH - 1) - 1;
  localparam int SMIN   = -(2 ** (WIDTH - 1));

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             carry_in = 1'b0;
  logic             sub = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  int vectors = 0;
  int miscompares = 0;
  int cycle = 0;
  int ready_mode = 0;
  int phase = 0;
  bit check_lat = 1'b0;

  typedef struct {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             o;
    int               t;
  } exp_t;

  exp_t q[$];

  pipelined_adder #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .carry_in (carry_in),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .carry_out(carry_out),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle = cycle + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Reference: plain unsigned and signed integer arithmetic on the operands.
  function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                 input logic cv, input logic sv, input int t);
    exp_t             m;
    logic [WIDTH-1:0] be;
    int unsigned      total;
    int               ssum;
    be    = sv ? ~bv : bv;
    total = int'(av) + int'(be) + int'(cv);
    ssum  = int'($signed(av)) + int'($signed(be)) + int'(cv);
    m.s   = total[WIDTH-1:0];
    m.c   = total[WIDTH];
    m.o   = (ssum > SMAX) || (ssum < SMIN);
    m.t   = t;
    return m;
  endfunction

  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1: begin
        out_ready = ((phase % 3) == 0);
        phase++;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  logic             prev_stall = 1'b0;
  logic [WIDTH-1:0] prev_sum;
  logic             prev_c;
  logic             prev_o;

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      checkOutput("in_ready", 32'(in_ready), 32'(!(out_valid && !out_ready)));
      if (prev_stall) begin
        checkOutput("stall_valid", 32'(out_valid), 32'd1);
        checkOutput("stall_sum", 32'(sum), 32'(prev_sum));
        checkOutput("stall_carry", 32'(carry_out), 32'(prev_c));
        checkOutput("stall_ovf", 32'(overflow), 32'(prev_o));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checkOutput("unexpected_out", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          checkOutput("sum", 32'(sum), 32'(e.s));
          checkOutput("carry_out", 32'(carry_out), 32'(e.c));
          checkOutput("overflow", 32'(overflow), 32'(e.o));
          if (check_lat) checkOutput("latency", 32'(cycle - e.t - 1), 32'(STAGES - 1));
        end
      end
      if (in_valid && in_ready) q.push_back(model(a, b, carry_in, sub, cycle));
      prev_stall = out_valid && !out_ready;
      prev_sum   = sum;
      prev_c     = carry_out;
      prev_o     = overflow;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic applyStimulus(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                               input logic cv, input logic sv);
    int waited;
    waited   = 0;
    a        = av;
    b        = bv;
    carry_in = cv;
    sub      = sv;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) checkOutput("accept_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idleCycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (q.size() != 0 && w < 200) begin
      @(posedge clk);
      w++;
    end
    #1;
    checkOutput("drain_empty", 32'(q.size()), 32'd0);
  endtask

  initial begin
    #1;
    checkOutput("reset_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_sum", 32'(sum), 32'd0);
    checkOutput("reset_carry", 32'(carry_out), 32'd0);
    checkOutput("reset_ovf", 32'(overflow), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);

    $display("[TB] directed carry, overflow and subtract cases");
    check_lat = 1'b1;
    applyStimulus(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    applyStimulus(16'h0005, 16'h0007, 1'b1, 1'b1);
    applyStimulus(16'h8000, 16'h0001, 1'b1, 1'b1);
    drain();

    $display("[TB] back-to-back throughput");
    for (int i = 0; i < 8; i++) applyStimulus(16'(i), 16'(32'h1000 * i), 1'b0, 1'b0);
    drain();

    $display("[TB] backpressure stream");
    check_lat  = 1'b0;
    phase      = 0;
    ready_mode = 1;
    for (int i = 0; i < 8; i++) applyStimulus(16'(i), 16'(32'h1000 * i), 1'b0, 1'b0);
    drain();

    $display("[TB] reset with transactions in flight");
    ready_mode = 0;
    idleCycles(2);
    applyStimulus(16'h1111, 16'h2222, 1'b0, 1'b0);
    applyStimulus(16'hABCD, 16'h1357, 1'b1, 1'b0);
    applyStimulus(16'h4000, 16'h0FFF, 1'b1, 1'b1);
    checkOutput("pre_reset_valid", 32'(out_valid), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset_sum", 32'(sum), 32'd0);
    checkOutput("async_reset_carry", 32'(carry_out), 32'd0);
    checkOutput("async_reset_ovf", 32'(overflow), 32'd0);
    q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("post_reset_idle", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    check_lat = 1'b1;
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    drain();

    $display("[TB] randomised traffic with random backpressure");
    check_lat  = 1'b0;
    ready_mode = 2;
    for (int i = 0; i < 40; i++) begin
      applyStimulus(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idleCycles(1);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
